mynios2_motor_pwm: RTL and testbench
====================================

// Module: mynios2_motor_pwm
// PURPOSE
//  Avalon-MM slave motor PWM generator with soft duty ramping and safe direction reversal.
//  Sits downstream of the system clock timer: its one-cycle timeout pulse drives tick and paces the ramp.
//  Drives one H-bridge channel (pwm_out, dir_out) and interrupts the Nios II core when the ramp reaches target.
// PARAMETERS
//  DATA_W        16       register/bus width; duty, period and step are DATA_W bits
//  RESET_PERIOD  16'd2500 PWM period in clk cycles after reset (20 kHz @ 50 MHz)
//  DEADTIME      8        clk cycles pwm_out is held low between dir_out change and drive
// PORTS
//  clk        in   1       system clock
//  reset      in   1       asynchronous, active-high reset
//  address    in   3       register select
//  chipselect in   1       slave select
//  write_n    in   1       active-low write strobe
//  writedata  in   DATA_W  write data
//  readdata   out  DATA_W  registered read data, 1-cycle latency
//  tick       in   1       ramp step pulse (system timer timeout), one clk wide
//  pwm_out    out  1       PWM drive
//  dir_out    out  1       direction to H-bridge
//  irq        out  1       at_target & irq_en
// BEHAVIOUR
//  Registers (wr = chipselect & ~write_n & address match):
//   0 STATUS  R: {13'b0, state!=IDLE, dir_out, at_target}; any write clears at_target
//   1 CONTROL RW: bit0 enable, bit1 irq_en, bit2 dir_req
//   2 PERIOD  RW; 3 TARGET RW (target duty); 4 DUTY R (current duty); 5 STEP RW (ramp step, 0 = jump)
//   6,7 read 0, writes ignored
//  Reset: all outputs 0; period=RESET_PERIOD; target=duty=step=control=0; state IDLE; pwm_cnt=0.
//  PWM counter: pwm_cnt counts 0..period-1, wraps to 0; period==0 -> cnt held 0, pwm_out 0.
//   Write to PERIOD forces pwm_cnt to 0 next cycle.
//  pwm_out (registered) = enable & ~deadtime_active & (cnt < duty_shadow);
//   duty_shadow loads duty only when cnt wraps to 0 (glitch-free); duty>=period -> 100 % high.
//  FSM (state advances only on clk; ramp moves only on tick):
//   IDLE: duty==eff_target & dir_out==dir_req. Leaves to RAMP when target changes, to BRAKE when dir_req!=dir_out.
//   RAMP: each tick: duty moves toward target by STEP, saturating exactly at target (no overshoot,
//    no wrap below 0 or above 2^DATA_W-1). On reaching target: set at_target, go IDLE.
//   BRAKE: each tick: duty ramps toward 0. At duty==0: toggle dir_out, load deadtime counter
//    with DEADTIME, go DEAD.
//   DEAD: pwm_out forced 0; count down DEADTIME clks; at 0 go RAMP.
//  eff_target = enable ? target : 0. Clearing enable drives pwm_out 0 immediately; duty ramps down.
//  STEP==0: duty jumps to target on the next tick.
//  Simultaneous events:
//   - at_target set and STATUS write in the same cycle -> set wins.
//   - New TARGET write during RAMP: retargets from the current duty, no restart.
//   - dir_req toggled during RAMP: go BRAKE on the next cycle.
//   - dir_req toggled back during BRAKE: return to RAMP, dir_out unchanged.
//   - dir_req toggled during DEAD: DEAD completes, then re-enters BRAKE.
//  readdata <= mux(address) each clk regardless of chipselect.
//  irq is combinational from registered at_target & irq_en.
//  Reset mid-operation: asynchronous return to reset values; pwm_out and dir_out low within the reset assertion.
// STRUCTURE
//  Shared package mynios2_pwm_pkg:
//   - register address localparams (ADDR_STATUS..ADDR_STEP)
//   - CONTROL bit indices
//   - FSM state encoding (IDLE, RAMP, BRAKE, DEAD)
//  One sub-module mynios2_pwm_counter:
//   - period counter, duty shadow, compare
//   - inputs: period, duty, force_zero, blank
//  Register file, ramp arithmetic and FSM stay in this module.
// TESTING
//  1 Reset, period=10, target=4, step=0, enable=1, one tick -> DUTY=4; pwm_out high 4 of every 10 clks from the next wrap; at_target=1.
//  2 step=3, target 0->10 -> DUTY reads 3,6,9,10 on successive ticks; irq=1 only after 10 if irq_en.
//  3 duty=6, toggle dir_req -> DUTY 3,0 on ticks; dir_out flips; pwm_out 0 for exactly DEADTIME clks; then ramps back to 6.
//  4 target=15, period=10 -> pwm_out constant high. Period write 0 -> pwm_out 0, cnt held 0.
//  5 at_target set and STATUS write in the same cycle -> at_target stays 1. Later write alone -> clears; irq drops next clk.
//  6 Assert reset mid-RAMP and mid-DEAD -> outputs 0 asynchronously; PERIOD reads 2500 after release.

Source files
------------

// File: rtl/mynios2_pwm_pkg.sv
// Shared definitions for the motor PWM slave: register map, CONTROL bit
// positions and the ramp/direction FSM state encoding.
package mynios2_pwm_pkg;

    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_CONTROL = 3'd1;
    localparam logic [2:0] ADDR_PERIOD  = 3'd2;
    localparam logic [2:0] ADDR_TARGET  = 3'd3;
    localparam logic [2:0] ADDR_DUTY    = 3'd4;
    localparam logic [2:0] ADDR_STEP    = 3'd5;

    localparam int unsigned CTRL_ENABLE  = 0;
    localparam int unsigned CTRL_IRQ_EN  = 1;
    localparam int unsigned CTRL_DIR_REQ = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RAMP  = 2'd1,
        ST_BRAKE = 2'd2,
        ST_DEAD  = 2'd3
    } pwm_state_t;

endpackage

// File: rtl/mynios2_pwm_counter.sv
// PWM period counter with a duty shadow register that only updates when the
// counter returns to zero, so a duty change never splits a PWM period.
module mynios2_pwm_counter
    import mynios2_pwm_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] period,
    input  logic [DATA_W-1:0] duty,
    input  logic              force_zero,
    input  logic              blank,
    output logic              pwm_out
);

    logic [DATA_W-1:0] pwm_cnt;
    logic [DATA_W-1:0] cnt_nxt;
    logic [DATA_W-1:0] duty_shadow;
    logic              wrap;

    // Next count: restart on a period write, hold at 0 for a zero period,
    // wrap after period-1 (>= also recovers when the period shrinks below cnt)
    always_comb begin
        cnt_nxt = pwm_cnt + 1'b1;
        wrap    = 1'b0;
        if (force_zero || (period == '0)) begin
            cnt_nxt = '0;
            wrap    = 1'b1;
        end else if (pwm_cnt >= (period - 1'b1)) begin
            cnt_nxt = '0;
            wrap    = 1'b1;
        end
    end

    // Counter, shadow load at wrap, and registered compare output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_cnt     <= '0;
            duty_shadow <= '0;
            pwm_out     <= 1'b0;
        end else begin
            pwm_cnt <= cnt_nxt;
            if (wrap) begin
                duty_shadow <= duty;
            end
            pwm_out <= ~blank & (period != '0) & (pwm_cnt < duty_shadow);
        end
    end

endmodule

// File: rtl/mynios2_motor_pwm.sv
// Avalon-MM motor PWM slave: register file, tick-paced duty ramp and a
// brake / deadtime sequence for safe H-bridge direction reversal.
module mynios2_motor_pwm
    import mynios2_pwm_pkg::*;
#(
    parameter int unsigned       DATA_W       = 16,
    parameter logic [DATA_W-1:0] RESET_PERIOD = 16'd2500,
    parameter int unsigned       DEADTIME     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    input  logic              tick,
    output logic              pwm_out,
    output logic              dir_out,
    output logic              irq
);

    localparam int unsigned       DEAD_W    = (DEADTIME < 2) ? 1 : $clog2(DEADTIME + 1);
    localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEADTIME);

    logic [2:0]        control;
    logic [DATA_W-1:0] period;
    logic [DATA_W-1:0] target;
    logic [DATA_W-1:0] step;
    logic [DATA_W-1:0] duty;
    logic [DATA_W-1:0] duty_nxt;
    logic [DATA_W-1:0] eff_target;
    logic [DATA_W-1:0] ramp_duty;
    logic [DATA_W-1:0] brake_duty;
    logic [DATA_W-1:0] rd_mux;
    logic [DEAD_W-1:0] dead_cnt;
    logic [DEAD_W-1:0] dead_nxt;
    logic              dir_nxt;
    logic              dir_req;
    logic              at_target;
    logic              at_set;
    logic              busy;
    logic              blank;
    logic              wr;
    logic              wr_status;
    logic              wr_control;
    logic              wr_period;
    logic              wr_target;
    logic              wr_step;
    pwm_state_t        state;
    pwm_state_t        state_nxt;

    // One ramp step from cur toward dst, clamped so it lands exactly on dst
    function automatic logic [DATA_W-1:0] ramp_toward(input logic [DATA_W-1:0] cur,
                                                      input logic [DATA_W-1:0] dst,
                                                      input logic [DATA_W-1:0] stp);
        logic [DATA_W-1:0] gap;
        if (stp == '0) begin
            return dst;
        end
        if (cur < dst) begin
            gap = dst - cur;
            return (gap <= stp) ? dst : cur + stp;
        end
        gap = cur - dst;
        return (gap <= stp) ? dst : cur - stp;
    endfunction

    assign wr         = chipselect & ~write_n;
    assign wr_status  = wr & (address == ADDR_STATUS);
    assign wr_control = wr & (address == ADDR_CONTROL);
    assign wr_period  = wr & (address == ADDR_PERIOD);
    assign wr_target  = wr & (address == ADDR_TARGET);
    assign wr_step    = wr & (address == ADDR_STEP);

    assign dir_req    = control[CTRL_DIR_REQ];
    assign eff_target = control[CTRL_ENABLE] ? target : '0;
    assign ramp_duty  = ramp_toward(duty, eff_target, step);
    assign brake_duty = ramp_toward(duty, '0, step);
    assign busy       = (state != ST_IDLE);
    assign blank      = ~control[CTRL_ENABLE] | (state == ST_DEAD);
    assign irq        = at_target & control[CTRL_IRQ_EN];

    // Bus-writable configuration registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            control <= '0;
            period  <= RESET_PERIOD;
            target  <= '0;
            step    <= '0;
        end else begin
            if (wr_control) control <= writedata[2:0];
            if (wr_period)  period  <= writedata;
            if (wr_target)  target  <= writedata;
            if (wr_step)    step    <= writedata;
        end
    end

    // Read mux for the registered read port
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_STATUS:  rd_mux[2:0] = {busy, dir_out, at_target};
            ADDR_CONTROL: rd_mux[2:0] = control;
            ADDR_PERIOD:  rd_mux      = period;
            ADDR_TARGET:  rd_mux      = target;
            ADDR_DUTY:    rd_mux      = duty;
            ADDR_STEP:    rd_mux      = step;
            default:      rd_mux      = '0;
        endcase
    end

    // Read data is captured every cycle, independent of chipselect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

    // FSM next state, duty update and direction sequencing
    always_comb begin
        state_nxt = state;
        duty_nxt  = duty;
        dir_nxt   = dir_out;
        dead_nxt  = dead_cnt;
        at_set    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (dir_req != dir_out) begin
                    state_nxt = ST_BRAKE;
                end else if (duty != eff_target) begin
                    state_nxt = ST_RAMP;
                end
            end
            ST_RAMP: begin
                if (dir_req != dir_out) begin
                    state_nxt = ST_BRAKE;
                end else if (duty == eff_target) begin
                    at_set    = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (tick) begin
                    duty_nxt = ramp_duty;
                    if (ramp_duty == eff_target) begin
                        at_set    = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_BRAKE: begin
                if (dir_req == dir_out) begin
                    state_nxt = ST_RAMP;
                end else if (duty == '0) begin
                    dir_nxt   = ~dir_out;
                    dead_nxt  = DEAD_LOAD;
                    state_nxt = ST_DEAD;
                end else if (tick) begin
                    duty_nxt = brake_duty;
                end
            end
            ST_DEAD: begin
                // Leaving on the last count keeps the bridge blanked for exactly DEADTIME clocks
                if (dead_cnt <= DEAD_W'(1)) begin
                    dead_nxt  = '0;
                    state_nxt = (dir_req != dir_out) ? ST_BRAKE : ST_RAMP;
                end else begin
                    dead_nxt = dead_cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state, duty, direction, deadtime and at_target registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            duty      <= '0;
            dir_out   <= 1'b0;
            dead_cnt  <= '0;
            at_target <= 1'b0;
        end else begin
            state    <= state_nxt;
            duty     <= duty_nxt;
            dir_out  <= dir_nxt;
            dead_cnt <= dead_nxt;
            if (at_set) begin
                at_target <= 1'b1;
            end else if (wr_status) begin
                at_target <= 1'b0;
            end
        end
    end

    mynios2_pwm_counter #(
        .DATA_W (DATA_W)
    ) u_counter (
        .clk        (clk),
        .reset      (reset),
        .period     (period),
        .duty       (duty),
        .force_zero (wr_period),
        .blank      (blank),
        .pwm_out    (pwm_out)
    );

endmodule

// File: tb/tb_mynios2_motor_pwm.sv
// Self-checking bench for mynios2_motor_pwm: directed scenarios plus a
// randomized ramp sequence checked against a tick-level duty model.
module tb_mynios2_motor_pwm;

    localparam int DEADTIME = 8;

    localparam logic [2:0] A_STATUS  = 3'd0;
    localparam logic [2:0] A_CONTROL = 3'd1;
    localparam logic [2:0] A_PERIOD  = 3'd2;
    localparam logic [2:0] A_TARGET  = 3'd3;
    localparam logic [2:0] A_DUTY    = 3'd4;
    localparam logic [2:0] A_STEP    = 3'd5;

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        tick;
    logic        pwm_out;
    logic        dir_out;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int m_duty   = 0;
    int m_target = 0;
    int m_step   = 0;
    int m_period = 2500;

    mynios2_motor_pwm #(
        .DATA_W       (16),
        .RESET_PERIOD (16'd2500),
        .DEADTIME     (DEADTIME)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .tick       (tick),
        .pwm_out    (pwm_out),
        .dir_out    (dir_out),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "simulation time limit exceeded");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // duty after one tick, from the ramp rules (step 0 jumps, never overshoots)
    function automatic int model_step(input int d, input int t, input int s);
        if (s == 0) return t;
        if (d < t) return (d + s < t) ? d + s : t;
        return (d - s > t) ? d - s : t;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        @(posedge clk);
        #1 d = readdata;
        @(negedge clk);
        chipselect = 1'b0;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic measure_high(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (pwm_out) cnt++;
        end
    endtask

    task automatic ramp_and_check(input string tag);
        logic [15:0] rd;
        int n;
        n = 0;
        while (m_duty != m_target && n < 80) begin
            m_duty = model_step(m_duty, m_target, m_step);
            pulse_tick();
            bus_read(A_DUTY, rd);
            check(tag, rd, m_duty);
            n++;
        end
    endtask

    initial begin
        logic [15:0] rd;
        int hi;
        int start;
        int diff;
        bit flipped;
        bit seen;

        reset      = 1'b1;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        tick       = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pwm", pwm_out, 0);
        check("rst_dir", dir_out, 0);
        check("rst_irq", irq, 0);
        check("rst_rdata", readdata, 0);
        reset = 1'b0;
        bus_read(A_PERIOD, rd);
        check("rst_period", rd, 2500);
        bus_read(A_STATUS, rd);
        check("rst_status", rd, 0);

        // 1: step 0 jumps to target on one tick
        m_period = 10;
        bus_write(A_PERIOD, 16'd10);
        bus_write(A_TARGET, 16'd4);
        bus_write(A_STEP, 16'd0);
        bus_write(A_CONTROL, 16'd1);
        m_target = 4; m_step = 0;
        idle(2);
        ramp_and_check("t1_duty");
        bus_read(A_STATUS, rd);
        check("t1_status", rd, 1);
        idle(25);
        measure_high(10, hi);
        check("t1_pwm_high", hi, 4);

        // 2: step 3 ramp 0 -> 10 with irq only at the end
        bus_write(A_TARGET, 16'd0);
        m_target = 0;
        idle(2);
        ramp_and_check("t2_down");
        bus_write(A_STATUS, 16'd0);
        bus_write(A_CONTROL, 16'd3);
        bus_write(A_STEP, 16'd3);
        bus_write(A_TARGET, 16'd10);
        m_step = 3; m_target = 10;
        idle(2);
        check("t2_irq_before", irq, 0);
        for (int i = 0; i < 4; i++) begin
            m_duty = model_step(m_duty, m_target, m_step);
            pulse_tick();
            bus_read(A_DUTY, rd);
            check("t2_duty", rd, m_duty);
            check("t2_irq", irq, (m_duty == 10) ? 1 : 0);
        end

        // 3: direction reversal from duty 6 through brake and deadtime
        bus_write(A_TARGET, 16'd6);
        m_target = 6;
        idle(2);
        ramp_and_check("t3_to6");
        bus_write(A_STATUS, 16'd0);
        bus_write(A_CONTROL, 16'd7);
        idle(2);
        m_duty = model_step(m_duty, 0, m_step);
        pulse_tick();
        bus_read(A_DUTY, rd);
        check("t3_brake1", rd, m_duty);
        m_duty = model_step(m_duty, 0, m_step);
        pulse_tick();
        check("t3_dir_held", dir_out, 0);
        flipped = 1'b0;
        for (int i = 0; i < 4 && !flipped; i++) begin
            @(posedge clk);
            #1;
            if (dir_out) flipped = 1'b1;
        end
        check("t3_dir_flip", flipped, 1);
        @(negedge clk);
        bus_read(A_DUTY, rd);
        check("t3_brake0", rd, 0);
        check("t3_pwm_dead", pwm_out, 0);
        idle(DEADTIME - 2);
        // first tick lands on the last deadtime clock and is ignored, second moves
        pulse_tick();
        pulse_tick();
        m_duty = model_step(0, m_target, m_step);
        bus_read(A_DUTY, rd);
        check("t3_dead_len", rd, m_duty);
        ramp_and_check("t3_back");
        bus_read(A_STATUS, rd);
        check("t3_status", rd, 3);
        idle(25);
        measure_high(10, hi);
        check("t3_pwm_high", hi, 6);

        // 4: duty above period is 100 %, zero period is 0 %
        bus_write(A_TARGET, 16'd15);
        m_target = 15;
        idle(2);
        ramp_and_check("t4_to15");
        idle(25);
        measure_high(20, hi);
        check("t4_full", hi, 20);
        bus_write(A_PERIOD, 16'd0);
        idle(3);
        measure_high(20, hi);
        check("t4_zero_period", hi, 0);
        bus_write(A_PERIOD, 16'd10);

        // 5: at_target set wins over a simultaneous STATUS write
        bus_write(A_STATUS, 16'd0);
        check("t5_irq_clr", irq, 0);
        bus_write(A_TARGET, 16'd9);
        m_target = 9;
        idle(2);
        m_duty = model_step(m_duty, m_target, m_step);
        pulse_tick();
        bus_read(A_DUTY, rd);
        check("t5_duty12", rd, m_duty);
        m_duty = model_step(m_duty, m_target, m_step);
        tick       = 1'b1;
        address    = A_STATUS;
        writedata  = '0;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        tick       = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        check("t5_irq_set_wins", irq, 1);
        bus_read(A_STATUS, rd);
        check("t5_status_set", rd, 3);
        bus_write(A_STATUS, 16'd0);
        check("t5_irq_drop", irq, 0);
        bus_read(A_STATUS, rd);
        check("t5_status_clr", rd, 2);

        // random ramps against the model
        for (int it = 0; it < 16; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                m_period = $urandom_range(4, 30);
                bus_write(A_PERIOD, 16'(m_period));
            end
            if ($urandom_range(0, 3) == 0) begin
                m_target = $urandom_range(0, 65535);
                m_step   = $urandom_range(4000, 65535);
            end else begin
                m_target = $urandom_range(0, m_period + 5);
                diff = (m_target > m_duty) ? m_target - m_duty : m_duty - m_target;
                if (diff > 40) m_step = $urandom_range(diff / 10 + 1, diff);
                else           m_step = $urandom_range(0, 5);
            end
            bus_write(A_STATUS, 16'd0);
            bus_write(A_STEP, 16'(m_step));
            bus_write(A_TARGET, 16'(m_target));
            start = m_duty;
            idle(2);
            ramp_and_check("rnd_duty");
            bus_read(A_STATUS, rd);
            check("rnd_status", rd, (m_target != start) ? 3 : 2);
            idle(2 * m_period + 2);
            measure_high(m_period, hi);
            check("rnd_pwm_high", hi, (m_duty < m_period) ? m_duty : m_period);
        end

        // 6a: reset in the middle of a ramp
        bus_write(A_PERIOD, 16'd10);
        bus_write(A_STEP, 16'd0);
        bus_write(A_TARGET, 16'd2);
        idle(2);
        pulse_tick();
        bus_write(A_STEP, 16'd1);
        bus_write(A_TARGET, 16'd9);
        idle(2);
        pulse_tick();
        pulse_tick();
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (pwm_out) seen = 1'b1;
        end
        check("t6_pwm_active", seen, 1);
        check("t6_dir_before", dir_out, 1);
        #2 reset = 1'b1;
        #1;
        check("t6_ramp_pwm", pwm_out, 0);
        check("t6_ramp_dir", dir_out, 0);
        check("t6_ramp_irq", irq, 0);
        @(negedge clk);
        reset = 1'b0;
        m_duty = 0; m_target = 0; m_step = 0; m_period = 2500;
        bus_read(A_PERIOD, rd);
        check("t6_period", rd, 2500);
        bus_read(A_DUTY, rd);
        check("t6_duty", rd, 0);
        bus_read(A_CONTROL, rd);
        check("t6_control", rd, 0);

        // 6b: reset while blanked in deadtime
        bus_write(A_CONTROL, 16'd5);
        flipped = 1'b0;
        for (int i = 0; i < 6 && !flipped; i++) begin
            @(posedge clk);
            #1;
            if (dir_out) flipped = 1'b1;
        end
        check("t6_dead_flip", flipped, 1);
        @(negedge clk);
        bus_read(A_STATUS, rd);
        check("t6_dead_status", rd, 6);
        #2 reset = 1'b1;
        #1;
        check("t6_dead_dir", dir_out, 0);
        check("t6_dead_pwm", pwm_out, 0);
        @(negedge clk);
        reset = 1'b0;
        bus_read(A_PERIOD, rd);
        check("t6_dead_period", rd, 2500);
        bus_read(A_STATUS, rd);
        check("t6_dead_status0", rd, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
